// File: rtl/commit_pkg.sv
// Shared types for the commit unit: ROB entry kinds, store-handshake states
// and the store byte-enable helper.
package commit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int MEM_BE_W   = 4;

  // ROB entry kind encoding as delivered on rob_kind.
  typedef enum logic [1:0] {
    KIND_REG = 2'b00,
    KIND_SB  = 2'b01,
    KIND_SH  = 2'b10,
    KIND_SW  = 2'b11
  } kind_e;

  // RUN retires register writes; ST_REQ/ST_WAIT walk one store to memory.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  // Byte lanes touched by a store of the given kind at byte offset off.
  function automatic logic [MEM_BE_W-1:0] byte_enable(input kind_e kind,
                                                      input logic [1:0] off);
    case (kind)
      KIND_SB: byte_enable = 4'b0001 << off;
      KIND_SH: byte_enable = 4'b0011 << {off[1], 1'b0};
      KIND_SW: byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/commit_store_fsm.sv
// Store handshake for the head-of-ROB store: captures address, lane-replicated
// data and byte enables on start, then requests and waits for completion.
module commit_store_fsm
  import commit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  kind_e               start_kind,
  input  logic [XLEN-1:0]     start_addr,
  input  logic [XLEN-1:0]     sb_data,
  input  logic                mem_gnt,
  input  logic                mem_done,
  output state_e              state,
  output logic                mem_req,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [MEM_BE_W-1:0] mem_be,
  output logic                sb_pop,
  output logic                complete
);

  state_e                state_nx;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       data_q;
  logic [MEM_BE_W-1:0]   be_q;

  // Replicate store data into every byte lane it may land in.
  function automatic logic [XLEN-1:0] lanes(input kind_e k, input logic [XLEN-1:0] d);
    case (k)
      KIND_SB: lanes = {(XLEN/8){d[7:0]}};
      KIND_SH: lanes = {(XLEN/16){d[15:0]}};
      default: lanes = d;
    endcase
  endfunction

  // State register plus the request payload captured when a store starts.
  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // pre-edge values, independent of statement order.
  // NOTE: payload registers are reset too, so mem_addr/wdata/be never show X
  // after reset even though they only matter while mem_req is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr_q <= {start_addr[XLEN-1:2], 2'b00};
        data_q <= lanes(start_kind, sb_data);
        be_q   <= byte_enable(start_kind, start_addr[1:0]);
      end
    end
  end

  // Next state and handshake outputs.
  // NOTE: every output gets a default before the case, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    sb_pop   = 1'b0;
    complete = 1'b0;
    case (state)
      RUN: begin
        if (start) state_nx = ST_REQ;
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (mem_done) begin
            complete = 1'b1;
            sb_pop   = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          complete = 1'b1;
          sb_pop   = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign mem_be    = be_q;

endmodule

// File: rtl/commit_unit.sv
// In-order commit unit: retires up to COMMIT_WIDTH ready register writes per
// cycle from the ROB head window and hands head stores to commit_store_fsm.
// Optional feature macro: COMMIT_STATS_EN adds saturating retirement and
// store-stall counters (stat_retired, stat_st_stall).
module commit_unit
  import commit_pkg::*;
#(
  parameter  int ROB_DEPTH    = 128,
  parameter  int COMMIT_WIDTH = 2,
  parameter  int XLEN         = 32,
  localparam int CW           = COMMIT_WIDTH,
  localparam int IDXW         = $clog2(ROB_DEPTH),
  localparam int POPW         = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rob_empty,
  input  logic [CW-1:0]          rob_vld,
  input  logic [CW-1:0]          rob_done,
  input  logic [2*CW-1:0]        rob_kind,
  input  logic [5*CW-1:0]        rob_rd,
  input  logic [XLEN*CW-1:0]     rob_val,
  input  logic [XLEN-1:0]        sb_data,
  output logic                   sb_pop,
  output logic [CW-1:0]          rf_we,
  output logic [5*CW-1:0]        rf_waddr,
  output logic [XLEN*CW-1:0]     rf_wdata,
  output logic [IDXW*CW-1:0]     rf_wtag,
  output logic [IDXW-1:0]        rob_head,
  output logic [POPW-1:0]        rob_pop,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [MEM_BE_W-1:0]    mem_be,
  input  logic                   mem_gnt,
  input  logic                   mem_done
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]            stat_retired,
  output logic [31:0]            stat_st_stall
`endif
);

  state_e          state;
  logic            in_run;
  logic            stop;
  logic            store_start;
  logic            st_complete;
  logic [CW-1:0]   ret_mask;
  logic [POPW-1:0] k;

  // Retirement is only decided in RUN and never while reset is asserted.
  assign in_run = (state == RUN) && reset;

  // Count leading retire-ready register writes; a store at slot 0 starts the
  // store handshake instead, a store further up simply ends the group.
  always_comb begin
    k           = '0;
    ret_mask    = '0;
    stop        = 1'b0;
    store_start = 1'b0;
    for (int i = 0; i < CW; i++) begin
      if (!stop) begin
        if (rob_vld[i] && rob_done[i] && kind_e'(rob_kind[2*i +: 2]) == KIND_REG) begin
          ret_mask[i] = 1'b1;
          k           = k + POPW'(1);
        end else begin
          stop = 1'b1;
          if (i == 0 && rob_vld[0] && rob_done[0]) store_start = 1'b1;
        end
      end
    end
    if (!in_run || rob_empty) begin
      k           = '0;
      ret_mask    = '0;
      store_start = 1'b0;
    end
  end

  // Register-file write port per slot; rd==0 retires without a write.
  always_comb begin
    rf_we   = '0;
    rf_wtag = '0;
    for (int i = 0; i < CW; i++) begin
      rf_we[i]             = ret_mask[i] && (rob_rd[5*i +: 5] != 5'd0);
      rf_wtag[IDXW*i +: IDXW] = rob_head + IDXW'(i);
    end
  end

  assign rf_waddr = rob_rd;
  assign rf_wdata = rob_val;
  assign rob_pop  = in_run ? k : (st_complete ? POPW'(1) : '0);

  // Head pointer advances by the number of entries retired; wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rob_head <= '0;
    else        rob_head <= rob_head + IDXW'(rob_pop);
  end

  commit_store_fsm #(
    .XLEN(XLEN)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .start      (store_start),
    .start_kind (kind_e'(rob_kind[1:0])),
    .start_addr (rob_val[XLEN-1:0]),
    .sb_data    (sb_data),
    .mem_gnt    (mem_gnt),
    .mem_done   (mem_done),
    .state      (state),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .sb_pop     (sb_pop),
    .complete   (st_complete)
  );

`ifdef COMMIT_STATS_EN
  logic [32:0] retired_sum;
  assign retired_sum = {1'b0, stat_retired} + 33'(rob_pop);

  // Saturating counters: total retirements and cycles spent on a store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_retired  <= '0;
      stat_st_stall <= '0;
    end else begin
      stat_retired <= retired_sum[32] ? 32'hFFFF_FFFF : retired_sum[31:0];
      if (state != RUN && stat_st_stall != 32'hFFFF_FFFF)
        stat_st_stall <= stat_st_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit (CW=2, ROB 128, XLEN 32). Expected values are
// queued as each step is driven and popped when the outputs are compared.
module tb_commit_unit;

  localparam int CW   = 2;
  localparam int XLEN = 32;
  localparam int IDXW = 7;
  localparam int POPW = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 rob_empty;
  logic [CW-1:0]        rob_vld, rob_done;
  logic [2*CW-1:0]      rob_kind;
  logic [5*CW-1:0]      rob_rd;
  logic [XLEN*CW-1:0]   rob_val;
  logic [XLEN-1:0]      sb_data;
  logic                 sb_pop;
  logic [CW-1:0]        rf_we;
  logic [5*CW-1:0]      rf_waddr;
  logic [XLEN*CW-1:0]   rf_wdata;
  logic [IDXW*CW-1:0]   rf_wtag;
  logic [IDXW-1:0]      rob_head;
  logic [POPW-1:0]      rob_pop;
  logic                 mem_req;
  logic [XLEN-1:0]      mem_addr, mem_wdata;
  logic [3:0]           mem_be;
  logic                 mem_gnt, mem_done;

  commit_unit #(.ROB_DEPTH(128), .COMMIT_WIDTH(CW), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .rob_empty(rob_empty), .rob_vld(rob_vld),
    .rob_done(rob_done), .rob_kind(rob_kind), .rob_rd(rob_rd), .rob_val(rob_val),
    .sb_data(sb_data), .sb_pop(sb_pop), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wtag(rf_wtag), .rob_head(rob_head), .rob_pop(rob_pop),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_done(mem_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic expect_val(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the observed value.
  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard: observed %h with no expectation queued", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic set_slot(input int i, input logic v, input logic d,
                          input logic [1:0] kd, input logic [4:0] rd,
                          input logic [31:0] val);
    rob_vld[i]             = v;
    rob_done[i]            = d;
    rob_kind[2*i +: 2]     = kd;
    rob_rd[5*i +: 5]       = rd;
    rob_val[XLEN*i +: XLEN] = val;
  endtask

  task automatic idle_slots();
    set_slot(0, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
    set_slot(1, 1'b0, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0; rob_empty = 1'b0; sb_data = '0; mem_gnt = 1'b0; mem_done = 1'b0;
    rob_vld = '0; rob_done = '0; rob_kind = '0; rob_rd = '0; rob_val = '0;
    #1;
    // Reset state
    expect_val("rst_head", 0);  expect_val("rst_req", 0); expect_val("rst_we", 0);
    expect_val("rst_pop", 0);   expect_val("rst_sbpop", 0);
    check(64'(rob_head)); check(64'(mem_req)); check(64'(rf_we));
    check(64'(rob_pop)); check(64'(sb_pop));
    tick();
    reset = 1'b1;
    tick();

    // Two ready register writes retire together
    set_slot(0, 1, 1, 2'b00, 5'd5, 32'hA);
    set_slot(1, 1, 1, 2'b00, 5'd6, 32'hB);
    expect_val("dual_we", 2'b11); expect_val("dual_pop", 2);
    expect_val("dual_waddr", {5'd6, 5'd5}); expect_val("dual_wdata", {32'hB, 32'hA});
    expect_val("dual_wtag", {7'd1, 7'd0});
    #1;
    check(64'(rf_we)); check(64'(rob_pop)); check(64'(rf_waddr));
    check(64'(rf_wdata)); check(64'(rf_wtag));
    tick();
    expect_val("dual_head", 2); check(64'(rob_head));

    // Stop at first not-done slot
    set_slot(0, 1, 1, 2'b00, 5'd3, 32'h33);
    set_slot(1, 1, 0, 2'b00, 5'd8, 32'h88);
    expect_val("part_pop", 1); expect_val("part_we", 2'b01);
    #1; check(64'(rob_pop)); check(64'(rf_we));
    tick();
    set_slot(0, 1, 0, 2'b00, 5'd8, 32'h88);
    set_slot(1, 0, 0, 2'b00, 5'd0, 32'h0);
    expect_val("nd_pop", 0); expect_val("nd_head", 3);
    #1; check(64'(rob_pop)); check(64'(rob_head));
    tick();

    // rd==0 retires without a write
    set_slot(0, 1, 1, 2'b00, 5'd0, 32'h1);
    set_slot(1, 1, 1, 2'b00, 5'd7, 32'h2);
    expect_val("rd0_pop", 2); expect_val("rd0_we", 2'b10);
    #1; check(64'(rob_pop)); check(64'(rf_we));
    tick();

    // rob_empty blocks retirement
    rob_empty = 1'b1;
    expect_val("empty_pop", 0); expect_val("empty_we", 0);
    #1; check(64'(rob_pop)); check(64'(rf_we));
    tick();
    rob_empty = 1'b0;

    // Advance head from 5 to 127, then wrap
    set_slot(0, 1, 1, 2'b00, 5'd1, 32'h0);
    set_slot(1, 1, 1, 2'b00, 5'd2, 32'h0);
    for (int n = 0; n < 61; n++) tick();
    expect_val("pre_wrap_head", 127); expect_val("wrap_tag", {7'd0, 7'd127});
    expect_val("wrap_pop", 2);
    #1; check(64'(rob_head)); check(64'(rf_wtag)); check(64'(rob_pop));
    tick();
    expect_val("wrap_head", 1); check(64'(rob_head));

    // Reg write then SH in slot 1: only the reg retires
    set_slot(0, 1, 1, 2'b00, 5'd4, 32'h44);
    set_slot(1, 1, 1, 2'b10, 5'd0, 32'h202);
    sb_data = 32'h0000_1234;
    expect_val("grp_pop", 1); expect_val("grp_we", 2'b01); expect_val("grp_req", 0);
    #1; check(64'(rob_pop)); check(64'(rf_we)); check(64'(mem_req));
    tick();
    // SH now at slot 0 with a ready reg behind it
    set_slot(0, 1, 1, 2'b10, 5'd0, 32'h202);
    set_slot(1, 1, 1, 2'b00, 5'd9, 32'h99);
    expect_val("sh_start_pop", 0); expect_val("sh_start_we", 0);
    #1; check(64'(rob_pop)); check(64'(rf_we));
    tick();
    // ST_REQ with grant and done together
    mem_gnt = 1'b1; mem_done = 1'b1;
    expect_val("sh_req", 1); expect_val("sh_be", 4'b1100); expect_val("sh_addr", 32'h200);
    expect_val("sh_wdata", 32'h1234_1234); expect_val("sh_pop", 1);
    expect_val("sh_sbpop", 1); expect_val("sh_we", 0);
    #1; check(64'(mem_req)); check(64'(mem_be)); check(64'(mem_addr));
    check(64'(mem_wdata)); check(64'(rob_pop)); check(64'(sb_pop)); check(64'(rf_we));
    tick();
    mem_gnt = 1'b0; mem_done = 1'b0; idle_slots();
    expect_val("sh_head", 3); expect_val("sh_req_end", 0);
    #1; check(64'(rob_head)); check(64'(mem_req));

    // SB at 0x103: grant after 3 cycles, done 2 cycles later
    set_slot(0, 1, 1, 2'b01, 5'd0, 32'h103);
    sb_data = 32'h0000_005A;
    tick();
    for (int n = 0; n < 3; n++) begin
      expect_val("sb_req", 1); expect_val("sb_be", 4'b1000);
      expect_val("sb_addr", 32'h100); expect_val("sb_wdata", 32'h5A5A_5A5A);
      #1; check(64'(mem_req)); check(64'(mem_be)); check(64'(mem_addr)); check(64'(mem_wdata));
      tick();
    end
    mem_gnt = 1'b1;
    expect_val("sb_gnt_req", 1); expect_val("sb_gnt_pop", 0);
    #1; check(64'(mem_req)); check(64'(rob_pop));
    tick();
    mem_gnt = 1'b0;
    expect_val("sb_wait_req", 0); expect_val("sb_wait_pop", 0); expect_val("sb_wait_sbpop", 0);
    #1; check(64'(mem_req)); check(64'(rob_pop)); check(64'(sb_pop));
    tick();
    mem_done = 1'b1;
    expect_val("sb_done_pop", 1); expect_val("sb_done_sbpop", 1); expect_val("sb_done_we", 0);
    #1; check(64'(rob_pop)); check(64'(sb_pop)); check(64'(rf_we));
    tick();
    mem_done = 1'b0; idle_slots();
    expect_val("sb_head", 4); check(64'(rob_head));

    // SW reaches ST_WAIT, then reset mid-store
    set_slot(0, 1, 1, 2'b11, 5'd0, 32'h300);
    sb_data = 32'hDEAD_BEEF;
    tick();
    expect_val("sw_be", 4'b1111); expect_val("sw_wdata", 32'hDEAD_BEEF);
    #1; check(64'(mem_be)); check(64'(mem_wdata));
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    expect_val("sw_wait_req", 0); check(64'(mem_req));
    #1;
    reset = 1'b0; mem_done = 1'b1;
    #1;
    expect_val("rstmid_req", 0); expect_val("rstmid_head", 0);
    expect_val("rstmid_sbpop", 0); expect_val("rstmid_pop", 0);
    check(64'(mem_req)); check(64'(rob_head)); check(64'(sb_pop)); check(64'(rob_pop));
    reset = 1'b1; mem_done = 1'b0;
    set_slot(0, 1, 1, 2'b00, 5'd1, 32'h11);
    #1;
    expect_val("post_rst_pop", 1); expect_val("post_rst_we", 2'b01);
    check(64'(rob_pop)); check(64'(rf_we));
    tick();
    expect_val("post_rst_head", 1); check(64'(rob_head));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
